// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes, protection default and the command FSM state encoding.
package axi_lite_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_AW_W,
        ST_WR_B,
        ST_RD_AR,
        ST_RD_R,
        ST_RSP,
        ST_HALT
    } state_e;

    // A timeout of 0 still needs a 1-bit counter so the port widths stay legal.
    function automatic int unsigned wdog_width(input int unsigned t);
        return (t == 0) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/axi_lite_wdog.sv
// Response watchdog: counts enabled cycles since the last clear and flags the final allowed cycle.
module axi_lite_wdog
    import axi_lite_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = wdog_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset || clr)
            cnt <= '0;
        else if (en && cnt != LAST)
            cnt <= cnt + 1'b1;
    end

    // Asserted during the TIMEOUT_CYCLES-th enabled cycle, so the waiter leaves on that edge.
    assign expired = (TIMEOUT_CYCLES != 0) && en && (cnt == LAST);

endmodule

// File: rtl/axi_lite_master_cmd.sv
// Single-outstanding AXI4-Lite initiator: turns register commands into AW/W/B or AR/R
// transactions and returns one response per command, halting after a response timeout.
module axi_lite_master_cmd
    import axi_lite_pkg::*;
#(
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 16,
    parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
    input  logic                            m_axi_aclk,
    input  logic                            m_axi_areset,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    output logic                            halted,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                      m_axi_awprot,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                      m_axi_arprot,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready
);

    state_e state;
    logic   aw_done, w_done, wd_en, wd_expired;

    assign m_axi_awprot = AXI_PROT_DEFAULT;
    assign m_axi_arprot = AXI_PROT_DEFAULT;

    // A channel counts as done if it already handshook or is handshaking this cycle.
    assign aw_done = !m_axi_awvalid || m_axi_awready;
    assign w_done  = !m_axi_wvalid  || m_axi_wready;
    assign wd_en   = (state == ST_WR_B) || (state == ST_RD_R);

    axi_lite_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clock   (m_axi_aclk),
        .reset   (m_axi_areset),
        .clr     (!wd_en),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state         <= ST_IDLE;
            cmd_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= AXI_RESP_OKAY;
            rsp_timeout   <= 1'b0;
            halted        <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            m_axi_awaddr  <= cmd_addr;
                            m_axi_wdata   <= cmd_wdata;
                            m_axi_wstrb   <= cmd_wstrb;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= ST_WR_AW_W;
                        end else begin
                            m_axi_araddr  <= cmd_addr;
                            m_axi_arvalid <= 1'b1;
                            state         <= ST_RD_AR;
                        end
                    end
                end
                ST_WR_AW_W: begin
                    if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
                    if (aw_done && w_done) begin
                        m_axi_bready <= 1'b1;
                        state        <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    if (m_axi_bvalid && m_axi_bready) begin
                        m_axi_bready <= 1'b0;
                        rsp_rdata    <= '0;
                        rsp_resp     <= m_axi_bresp;
                        rsp_timeout  <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= ST_RSP;
                    end else if (wd_expired) begin
                        m_axi_bready <= 1'b0;
                        rsp_rdata    <= '0;
                        rsp_resp     <= AXI_RESP_SLVERR;
                        rsp_timeout  <= 1'b1;
                        rsp_valid    <= 1'b1;
                        state        <= ST_RSP;
                    end
                end
                ST_RD_AR: begin
                    if (m_axi_arvalid && m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= ST_RD_R;
                    end
                end
                ST_RD_R: begin
                    if (m_axi_rvalid && m_axi_rready) begin
                        m_axi_rready <= 1'b0;
                        rsp_rdata    <= m_axi_rdata;
                        rsp_resp     <= m_axi_rresp;
                        rsp_timeout  <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= ST_RSP;
                    end else if (wd_expired) begin
                        m_axi_rready <= 1'b0;
                        rsp_rdata    <= '0;
                        rsp_resp     <= AXI_RESP_SLVERR;
                        rsp_timeout  <= 1'b1;
                        rsp_valid    <= 1'b1;
                        state        <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        // A timed-out slave is in an unknown state; only reset recovers.
                        if (rsp_timeout) begin
                            halted <= 1'b1;
                            state  <= ST_HALT;
                        end else begin
                            cmd_ready <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                end
                ST_HALT: begin
                    cmd_ready <= 1'b0;
                    halted    <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master_cmd.sv
// Directed bench for axi_lite_master_cmd against a small negedge-driven AXI4-Lite slave model.
module tb_axi_lite_master_cmd;

    logic        clk, rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout, halted;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    axi_lite_master_cmd #(
        .C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(16), .TIMEOUT_CYCLES(16)
    ) dut (
        .m_axi_aclk(clk), .m_axi_areset(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .halted(halted),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
        .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
        .m_axi_rready(rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- slave model (configured by the test, updated on negedge) ----------------
    int          aw_dly;
    logic        b_en, r_en;
    logic [1:0]  bresp_cfg, rresp_cfg;
    logic [31:0] mem [16];
    logic        aw_have, w_have, ar_have, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [15:0] aw_addr_l, ar_addr_l;
    logic [31:0] w_data_l;
    logic [3:0]  w_strb_l;
    int          aw_age, aw_cnt, w_cnt, b_cnt, r_cnt;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            awready = 0; wready = 0; bvalid = 0; bresp = 0;
            arready = 0; rvalid = 0; rdata = 0; rresp = 0;
            aw_have = 0; w_have = 0; ar_have = 0; aw_age = 0;
            aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
            for (int i = 0; i < 16; i++) mem[i] = 0;
        end else begin
            // retire handshakes that happened on the posedge just passed
            if (aw_hs) aw_have = 1;
            if (w_hs)  w_have = 1;
            if (ar_hs) ar_have = 1;
            if (b_hs) begin bvalid = 0; aw_have = 0; w_have = 0; b_cnt++; end
            if (r_hs) begin rvalid = 0; ar_have = 0; r_cnt++; end
            if (aw_have && w_have && !bvalid && b_en) begin
                for (int i = 0; i < 4; i++)
                    if (w_strb_l[i]) mem[aw_addr_l[5:2]][8*i +: 8] = w_data_l[8*i +: 8];
                bvalid = 1; bresp = bresp_cfg;
            end
            if (ar_have && !rvalid && r_en) begin
                rvalid = 1; rdata = mem[ar_addr_l[5:2]]; rresp = rresp_cfg;
            end
            awready = 0;
            if (awvalid && !aw_have) begin awready = (aw_age >= aw_dly); aw_age++; end
            wready  = wvalid && !w_have;
            arready = arvalid && !ar_have;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            ar_hs = arvalid && arready;
            b_hs  = bvalid && bready;
            r_hs  = rvalid && rready;
            if (aw_hs) begin aw_addr_l = awaddr; aw_cnt++; aw_age = 0; end
            if (w_hs)  begin w_data_l = wdata; w_strb_l = wstrb; w_cnt++; end
            if (ar_hs) ar_addr_l = araddr;
        end
    end

    // ---------------- checking helpers ----------------
    int checks, failures;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        chk("cmd_ready_before_issue", 32'(cmd_ready), 1);
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        step();
        cmd_valid = 0;
    endtask

    // lat counts cycles after the command handshake; start is the count already elapsed.
    task automatic wait_rsp(input int start, output int lat);
        lat = start;
        while (!rsp_valid && lat < 64) begin step(); lat++; end
        if (!rsp_valid) chk("rsp_valid_wait_expired", 32'(rsp_valid), 1);
    endtask

    task automatic ack_rsp();
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        chk("rsp_valid_after_ack", 32'(rsp_valid), 0);
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  bresp;
        logic [1:0]  rresp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input int idx, input vec_t v);
        int lat, b0, r0;
        b0 = b_cnt; r0 = r_cnt;
        bresp_cfg = v.bresp; rresp_cfg = v.rresp;
        issue(v.wr, v.addr, v.wdata, v.strb);
        wait_rsp(1, lat);
        chk($sformatf("v%0d_latency", idx), 32'(lat), 3);
        chk($sformatf("v%0d_rdata", idx), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d_resp", idx), 32'(rsp_resp), 32'(v.exp_resp));
        chk($sformatf("v%0d_timeout", idx), 32'(rsp_timeout), 0);
        if (v.wr) begin
            chk($sformatf("v%0d_slave_awaddr", idx), 32'(aw_addr_l), 32'(v.addr));
            chk($sformatf("v%0d_b_count", idx), 32'(b_cnt - b0), 1);
        end else begin
            chk($sformatf("v%0d_r_count", idx), 32'(r_cnt - r0), 1);
        end
        ack_rsp();
        chk($sformatf("v%0d_cmd_ready_after", idx), 32'(cmd_ready), 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int lat, n, b0, aw0;
        checks = 0; failures = 0;
        aw_dly = 0; b_en = 1; r_en = 1; bresp_cfg = 0; rresp_cfg = 0;
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0;

        vecs[0] = '{1'b1, 16'h1004, 32'h0000_00A5, 4'hF, 2'b00, 2'b00, 32'h0000_0000, 2'b00};
        vecs[1] = '{1'b0, 16'h1004, 32'h0,         4'h0, 2'b00, 2'b00, 32'h0000_00A5, 2'b00};
        vecs[2] = '{1'b0, 16'h1004, 32'h0,         4'h0, 2'b00, 2'b11, 32'h0000_00A5, 2'b11};
        vecs[3] = '{1'b1, 16'h1008, 32'h1234_5678, 4'h5, 2'b00, 2'b00, 32'h0000_0000, 2'b00};
        vecs[4] = '{1'b0, 16'h1008, 32'h0,         4'h0, 2'b00, 2'b00, 32'h0034_0078, 2'b00};
        vecs[5] = '{1'b1, 16'h100C, 32'hCAFE_F00D, 4'hF, 2'b10, 2'b00, 32'h0000_0000, 2'b10};
        vecs[6] = '{1'b0, 16'h100C, 32'h0,         4'h0, 2'b00, 2'b01, 32'hCAFE_F00D, 2'b01};

        repeat (3) step();
        chk("reset_cmd_ready", 32'(cmd_ready), 1);
        chk("reset_valids", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 0);
        chk("reset_rsp", 32'({rsp_resp, rsp_timeout, halted}), 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("prot_const", 32'({awprot, arprot}), 0);
        rst = 0;
        step();

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // W accepted three cycles ahead of AW
        aw_dly = 3; b0 = b_cnt; aw0 = aw_cnt;
        issue(1, 16'h1010, 32'hDEAD_BEEF, 4'hF);
        chk("t2_both_valid", 32'({awvalid, wvalid}), 32'b11);
        step();
        chk("t2_w_dropped", 32'({awvalid, wvalid}), 32'b10);
        chk("t2_awaddr_stable", 32'(awaddr), 32'h1010);
        step();
        chk("t2_aw_held", 32'({awvalid, wvalid}), 32'b10);
        wait_rsp(3, lat);
        chk("t2_latency", 32'(lat), 6);
        chk("t2_resp", 32'(rsp_resp), 0);
        ack_rsp();
        repeat (4) step();
        chk("t2_one_b", 32'(b_cnt - b0), 1);
        chk("t2_one_aw", 32'(aw_cnt - aw0), 1);
        chk("t2_no_extra_rsp", 32'(rsp_valid), 0);
        chk("t2_slave_wdata", w_data_l, 32'hDEAD_BEEF);
        aw_dly = 0;

        // response back-pressure
        rresp_cfg = 0; aw0 = aw_cnt;
        issue(0, 16'h1004, 32'h0, 4'h0);
        wait_rsp(1, lat);
        chk("t4_latency", 32'(lat), 3);
        for (int k = 0; k < 5; k++) begin
            cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h2000;
            step();
            chk("t4_rsp_held", 32'({rsp_valid, rsp_resp, rsp_timeout}), 32'b1000);
            chk("t4_rdata_held", rsp_rdata, 32'h0000_00A5);
            chk("t4_busy", 32'({cmd_ready, awvalid, wvalid, arvalid}), 0);
        end
        cmd_valid = 0;
        ack_rsp();
        step();
        chk("t4_no_new_aw", 32'(aw_cnt - aw0), 0);

        // B never arrives: watchdog
        b_en = 0;
        issue(1, 16'h1020, 32'h1111_1111, 4'hF);
        n = 0;
        for (int k = 0; k < 40 && !rsp_valid; k++) begin
            step();
            if (bready) n++;
        end
        chk("t5_wr_b_cycles", 32'(n), 16);
        chk("t5_timeout_rsp", 32'({rsp_valid, rsp_timeout, rsp_resp}), 32'b1110);
        chk("t5_timeout_rdata", rsp_rdata, 0);
        chk("t5_bready_dropped", 32'(bready), 0);
        chk("t5_not_halted_yet", 32'(halted), 0);
        ack_rsp();
        chk("t5_halted", 32'({halted, cmd_ready}), 32'b10);
        for (int k = 0; k < 4; k++) begin
            cmd_valid = 1; cmd_write = 0; cmd_addr = 16'h1004;
            step();
            chk("t5_halt_idle", 32'({cmd_ready, awvalid, wvalid, arvalid, bready, rready}), 0);
            chk("t5_halt_sticky", 32'(halted), 1);
        end
        cmd_valid = 0; b_en = 1;
        rst = 1;
        step();
        chk("t5_reset_clears_halt", 32'({halted, cmd_ready}), 32'b01);
        rst = 0;
        step();

        // reset while waiting for R
        r_en = 0;
        issue(0, 16'h1004, 32'h0, 4'h0);
        step(); step();
        chk("t6_in_rd_r", 32'({arvalid, rready}), 32'b01);
        rst = 1;
        step();
        chk("t6_reset_outputs", 32'({arvalid, rready, rsp_valid, cmd_ready}), 32'b0001);
        rst = 0; r_en = 1;
        step();
        issue(0, 16'h1004, 32'h0, 4'h0);
        wait_rsp(1, lat);
        chk("t6_read_latency", 32'(lat), 3);
        chk("t6_read_cleared_mem", rsp_rdata, 0);
        chk("t6_read_resp", 32'({rsp_resp, rsp_timeout}), 0);
        ack_rsp();
        run_vec(7, '{1'b1, 16'h1004, 32'h5A5A_0001, 4'hF, 2'b00, 2'b00, 32'h0, 2'b00});
        run_vec(8, '{1'b0, 16'h1004, 32'h0, 4'h0, 2'b00, 2'b00, 32'h5A5A_0001, 2'b00});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
